// File: rtl/sma_row_pipe.sv
// rtl/sma_row_pipe.sv - registered SMA PE row with double-buffered per-column configuration
// Optional macro SMA_ROW_PIPE_EN adds an output register P between R and OUT_ROW.
module sma_row_pipe #(
  parameter int COLS   = 12,
  parameter int DATA_W = 25,
  parameter int SEL_W  = 3,
  parameter int ALU_W  = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        EN,
  input  logic [ALU_W+2*SEL_W-1:0]    CONF_IN,
  input  logic                        CONF_VALID,
  output logic                        CONF_READY,
  input  logic                        CONF_COMMIT,
  output logic                        CONF_FULL,
  input  logic [COLS*DATA_W-1:0]      IN_NORTH,
  input  logic [COLS*DATA_W-1:0]      IN_SOUTH,
  input  logic [COLS*DATA_W-1:0]      IN_DL_S,
  input  logic [DATA_W-1:0]           IN_CONST_A,
  input  logic [DATA_W-1:0]           IN_CONST_B,
  output logic [COLS*DATA_W-1:0]      OUT_ROW
);

  localparam int CONF_W = ALU_W + 2 * SEL_W;
  localparam int CNT_W  = $clog2(COLS + 1);

  logic [CONF_W-1:0]      shadow [COLS];
  logic [CONF_W-1:0]      active [COLS];
  logic [CNT_W-1:0]       cnt;
  logic [COLS*DATA_W-1:0] r_row;
  logic [COLS*DATA_W-1:0] res_row;
  logic                   accept;

  assign CONF_FULL  = (cnt == CNT_W'(COLS));
  assign CONF_READY = !CONF_FULL;
  assign accept     = CONF_VALID && CONF_READY;

  // Accept and a full commit are mutually exclusive because READY is low while full.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      for (int i = 0; i < COLS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else if (accept) begin
      cnt       <= cnt + CNT_W'(1);
      shadow[0] <= CONF_IN;
      for (int i = 1; i < COLS; i++) begin
        shadow[i] <= shadow[i-1];
      end
    end else if (CONF_COMMIT && CONF_FULL) begin
      cnt <= '0;
      for (int i = 0; i < COLS; i++) begin
        active[i] <= shadow[i];
      end
    end
  end

  function automatic logic [DATA_W-1:0] pick(
    input logic [SEL_W-1:0]  sel,
    input logic [DATA_W-1:0] n,
    input logic [DATA_W-1:0] s,
    input logic [DATA_W-1:0] w,
    input logic [DATA_W-1:0] e,
    input logic [DATA_W-1:0] d,
    input logic [DATA_W-1:0] c,
    input logic [DATA_W-1:0] own
  );
    logic [DATA_W-1:0] v;
    v = '0;
    case (int'(sel))
      0:       v = n;
      1:       v = s;
      2:       v = w;
      3:       v = e;
      4:       v = d;
      5:       v = c;
      6:       v = own;
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] alu_op(
    input logic [ALU_W-1:0]  op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] v;
    logic [4:0]        sh;
    logic              big;
    sh  = b[4:0];
    big = (32'(sh) >= DATA_W);
    v   = '0;
    case (int'(op))
      0:       v = a + b;
      1:       v = a - b;
      2:       v = a & b;
      3:       v = a | b;
      4:       v = a ^ b;
      5:       v = a;
      6:       v = big ? '0 : (a << sh);
      7:       v = big ? '0 : (a >> sh);
      default: v = '0;
    endcase
    return v;
  endfunction

  for (genvar i = 0; i < COLS; i++) begin : g_col
    logic [CONF_W-1:0] cfg;
    logic [DATA_W-1:0] west;
    logic [DATA_W-1:0] east;
    logic [DATA_W-1:0] own;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;

    assign cfg = active[i];
    assign own = r_row[i*DATA_W +: DATA_W];

    // Neighbour links come from registered results, so no combinational ring exists.
    if (i == 0) begin : g_w0
      assign west = '0;
    end else begin : g_w
      assign west = r_row[(i-1)*DATA_W +: DATA_W];
    end
    if (i == COLS - 1) begin : g_e0
      assign east = '0;
    end else begin : g_e
      assign east = r_row[(i+1)*DATA_W +: DATA_W];
    end

    assign opa = pick(cfg[2*SEL_W-1:SEL_W], IN_NORTH[i*DATA_W +: DATA_W],
                      IN_SOUTH[i*DATA_W +: DATA_W], west, east,
                      IN_DL_S[i*DATA_W +: DATA_W], IN_CONST_A, own);
    assign opb = pick(cfg[SEL_W-1:0], IN_NORTH[i*DATA_W +: DATA_W],
                      IN_SOUTH[i*DATA_W +: DATA_W], west, east,
                      IN_DL_S[i*DATA_W +: DATA_W], IN_CONST_B, own);
    assign res_row[i*DATA_W +: DATA_W] = alu_op(cfg[CONF_W-1:2*SEL_W], opa, opb);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_row <= '0;
    end else if (EN) begin
      r_row <= res_row;
    end
  end

`ifdef SMA_ROW_PIPE_EN
  logic [COLS*DATA_W-1:0] p_row;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_row <= '0;
    end else if (EN) begin
      p_row <= r_row;
    end
  end

  assign OUT_ROW = p_row;
`else
  assign OUT_ROW = r_row;
`endif

endmodule

// File: tb/tb_sma_row_pipe.sv
// tb/tb_sma_row_pipe.sv - scoreboard bench for sma_row_pipe with COLS=4, DATA_W=25
module tb_sma_row_pipe;

  localparam int COLS = 4;
  localparam int DW   = 25;
  localparam int TW   = COLS * DW;

`ifdef SMA_ROW_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          EN;
  logic [9:0]    CONF_IN;
  logic          CONF_VALID;
  logic          CONF_READY;
  logic          CONF_COMMIT;
  logic          CONF_FULL;
  logic [TW-1:0] IN_NORTH;
  logic [TW-1:0] IN_SOUTH;
  logic [TW-1:0] IN_DL_S;
  logic [DW-1:0] IN_CONST_A;
  logic [DW-1:0] IN_CONST_B;
  logic [TW-1:0] OUT_ROW;

  sma_row_pipe #(.COLS(COLS), .DATA_W(DW), .SEL_W(3), .ALU_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN),
    .CONF_IN(CONF_IN), .CONF_VALID(CONF_VALID), .CONF_READY(CONF_READY),
    .CONF_COMMIT(CONF_COMMIT), .CONF_FULL(CONF_FULL),
    .IN_NORTH(IN_NORTH), .IN_SOUTH(IN_SOUTH), .IN_DL_S(IN_DL_S),
    .IN_CONST_A(IN_CONST_A), .IN_CONST_B(IN_CONST_B), .OUT_ROW(OUT_ROW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           tag;
    logic [101:0] exp;
    logic [101:0] mask;
    string        name;
  } ent_t;

  ent_t          sb[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [TW-1:0] r_model = '0;
  logic [TW-1:0] p_model = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: compare every queued expectation that is due at this sampling point.
  always @(negedge CLK) begin
    logic [101:0] act;
    act = {CONF_FULL, CONF_READY, OUT_ROW};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tag <= cyc) begin
        checks++;
        if ((act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc,
                   act & sb[i].mask, sb[i].exp & sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  function automatic logic [9:0] cw(input int alu, input int a, input int b);
    return {alu[3:0], a[2:0], b[2:0]};
  endfunction

  function automatic logic [TW-1:0] row(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                                        input logic [DW-1:0] c2, input logic [DW-1:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic stat(input logic rdy, input logic full);
    ent_t e;
    e.tag  = cyc + 1;
    e.exp  = {full, rdy, {TW{1'b0}}};
    e.mask = {2'b11, {TW{1'b0}}};
    e.name = "conf_status";
    sb.push_back(e);
  endtask

  // One clock edge; r_exp is the hand-computed R after the edge when e=1.
  task automatic tick(input logic e, input logic [TW-1:0] r_exp);
    ent_t x;
    EN = e;
    if (e) begin
      p_model = r_model;
      r_model = r_exp;
    end
    x.tag  = cyc + 1;
    x.exp  = {2'b00, PIPE ? p_model : r_model};
    x.mask = {2'b00, {TW{1'b1}}};
    x.name = "out_row";
    sb.push_back(x);
    @(negedge CLK);
  endtask

  task automatic hold();
    tick(1'b0, r_model);
  endtask

  task automatic word(input logic [9:0] w, input logic rdy, input logic full);
    CONF_VALID = 1'b1;
    CONF_IN    = w;
    stat(rdy, full);
    hold();
    CONF_VALID = 1'b0;
  endtask

  task automatic commit();
    CONF_COMMIT = 1'b1;
    stat(1'b1, 1'b0);
    hold();
    CONF_COMMIT = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; CONF_IN = '0; CONF_VALID = 1'b0; CONF_COMMIT = 1'b0;
    IN_NORTH = '0; IN_SOUTH = '0; IN_DL_S = '0; IN_CONST_A = '0; IN_CONST_B = '0;

    // reset and default north+north config
    stat(1'b1, 1'b0);
    hold(); hold(); hold();
    RST_N = 1'b1;
    IN_NORTH = row(5, 0, 0, 0);
    tick(1'b1, row(10, 0, 0, 0));
    IN_NORTH = row(0, 3, 0, 0);
    tick(1'b1, row(0, 6, 0, 0));

    // load/commit: first word lands in column 3
    IN_NORTH = row(7, 7, 7, 7); IN_CONST_A = 3; IN_CONST_B = 4;
    word(cw(0, 5, 5), 1, 0);
    word(cw(5, 0, 0), 1, 0);
    word(cw(5, 0, 0), 1, 0);
    word(cw(5, 0, 0), 0, 1);
    CONF_VALID = 1'b1; CONF_IN = cw(9, 0, 0);
    stat(1'b0, 1'b1);
    hold();
    commit();
    CONF_VALID = 1'b0;
    tick(1'b1, row(7, 7, 7, 7));
    IN_NORTH = row(1, 1, 1, 1);
    tick(1'b1, row(1, 1, 1, 7));

    // early commit is ignored
    word(cw(1, 0, 5), 1, 0);
    word(cw(1, 0, 5), 1, 0);
    commit();
    tick(1'b1, row(1, 1, 1, 7));
    word(cw(1, 0, 5), 1, 0);
    word(cw(1, 0, 5), 0, 1);
    commit();
    IN_NORTH = row(10, 10, 10, 10);
    tick(1'b1, row(6, 6, 6, 6));

    // neighbour shift west->east with a 2-cycle stall
    word(cw(5, 2, 0), 1, 0);
    word(cw(5, 2, 0), 1, 0);
    word(cw(5, 2, 0), 1, 0);
    word(cw(5, 0, 0), 0, 1);
    commit();
    IN_NORTH = row(9, 0, 0, 0);
    tick(1'b1, row(9, 6, 6, 6));
    IN_NORTH = '0;
    tick(1'b1, row(0, 9, 6, 6));
    hold(); hold();
    tick(1'b1, row(0, 0, 9, 6));
    tick(1'b1, row(0, 0, 0, 9));
    tick(1'b1, row(0, 0, 0, 0));

    // arithmetic edges: 0-1, shifts, wrap, unused opcode
    word(cw(9, 0, 0), 1, 0);
    word(cw(0, 0, 1), 1, 0);
    word(cw(6, 0, 5), 1, 0);
    word(cw(1, 7, 0), 0, 1);
    commit();
    IN_NORTH = row(1, 1, 25'h1FFFFFF, 5); IN_SOUTH = row(0, 0, 1, 0); IN_CONST_B = 24;
    tick(1'b1, row(25'h1FFFFFF, 25'h1000000, 0, 0));
    IN_CONST_B = 25;
    tick(1'b1, row(25'h1FFFFFF, 0, 0, 0));
    IN_CONST_B = 34;
    tick(1'b1, row(25'h1FFFFFF, 4, 0, 0));

    // logic ops, DL_S, own, east and right shift
    word(cw(7, 5, 4), 1, 0);
    word(cw(4, 3, 0), 1, 0);
    word(cw(3, 6, 4), 1, 0);
    word(cw(2, 4, 0), 0, 1);
    commit();
    IN_NORTH = row(25'h0F0F0F0, 0, 25'h123, 0); IN_SOUTH = '0;
    IN_DL_S = row(25'h0FF00FF, 25'h10, 0, 3); IN_CONST_A = 25'h1800000;
    tick(1'b1, row(25'h0F000F0, 25'h14, 25'h123, 25'h300000));
    tick(1'b1, row(25'h0F000F0, 25'h14, 25'h300123, 25'h300000));
    IN_DL_S = row(25'h0FF00FF, 1, 0, 25);
    tick(1'b1, row(25'h0F000F0, 25'h15, 25'h300123, 0));

    // asynchronous reset mid-load, released before the next edge
    word(cw(0, 0, 1), 1, 0);
    word(cw(0, 0, 1), 1, 0);
    #1 RST_N = 1'b0;
    #1 RST_N = 1'b1;
    r_model = '0;
    p_model = '0;
    stat(1'b1, 1'b0);
    hold();
    word(cw(0, 0, 1), 1, 0);
    word(cw(0, 0, 1), 1, 0);
    word(cw(0, 0, 1), 1, 0);
    word(cw(0, 0, 1), 0, 1);
    commit();
    IN_NORTH = row(1, 2, 3, 4); IN_SOUTH = row(10, 20, 30, 40);
    tick(1'b1, row(11, 22, 33, 44));
    tick(1'b1, row(11, 22, 33, 44));
    hold();

    repeat (2) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
